// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - state encodings and counter sizing for serial_adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // A one-bit adder still needs a one-bit counter to hold its step index.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/my_ha.sv
// rtl/my_ha.sv - one-bit half adder
module my_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - combinational full-adder cell built from two half adders
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0, c0, c1;

  my_ha u_ha0 (.a(x),  .b(y),  .s(s0), .c(c0));
  my_ha u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with valid/ready operand and result handshakes
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             cell_s, cell_co;

  serial_fa_cell u_cell (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SHIFT;
          sa_d    = a;
          sb_d    = b;
          sum_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
        sum_d   = (sum_q >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
        carry_d = cell_co;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cout_d  = cell_co;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv8, ir8, ov8, or8, co8;
  logic [7:0] a8, b8, s8;
  logic       iv1, ir1, ov1, or1, co1;
  logic [0:0] a1, b1, s1;

  int errors = 0;
  int checks = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold, input bit poke);
    int n;
    logic [8:0] exp, held;
    n = 0;
    while (!ir8 && n < 50) begin step(); n++; end
    check("in_ready_idle", ir8, 1);
    a8 = a; b8 = b; iv8 = 1'b1; or8 = (hold == 0);
    q8.push_back({1'b0, a} + {1'b0, b});
    step();
    iv8 = 1'b0;
    if (poke) begin iv8 = 1'b1; a8 = ~a; b8 = 8'h5A; end
    n = 0;
    while (!ov8 && n < 50) begin
      if (poke) check("in_ready_busy", ir8, 0);
      step();
      n++;
    end
    iv8 = 1'b0;
    check("latency", n, 8);
    check("sb_size", q8.size(), 1);
    exp = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
    check("result", {co8, s8}, exp);
    if (hold > 0) begin
      held = {co8, s8};
      repeat (hold) begin
        step();
        check("bp_valid", ov8, 1);
        check("bp_stable", {co8, s8}, held);
      end
      or8 = 1'b1;
    end
    step();
    check("out_valid_drop", ov8, 0);
    check("in_ready_back", ir8, 1);
  endtask

  initial begin
    int n;
    logic [1:0] exp1;
    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
    iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0;
    #1;
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_sum", s8, 0);
    check("rst_cout", co8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_op(8'h03, 8'h05, 0, 0);
    run_op(8'hFF, 8'h01, 0, 0);
    run_op(8'hFF, 8'hFF, 0, 0);
    run_op(8'h5C, 8'h2B, 5, 0);
    run_op(8'h81, 8'h7F, 0, 1);

    a8 = 8'h05; b8 = 8'h02; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    repeat (3) step();
    check("partial_sum", s8, 8'hE0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", ov8, 0);
    check("midrst_in_ready", ir8, 1);
    check("midrst_sum", s8, 0);
    check("midrst_cout", co8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      step();
      check("discarded_valid", ov8, 0);
    end
    run_op(8'h10, 8'h20, 0, 0);

    n = 0;
    while (!ir1 && n < 20) begin step(); n++; end
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1; or1 = 1'b1;
    q1.push_back(2'b10);
    step();
    iv1 = 1'b0;
    n = 0;
    while (!ov1 && n < 20) begin step(); n++; end
    check("w1_latency", n, 1);
    check("w1_sb_size", q1.size(), 1);
    exp1 = (q1.size() > 0) ? q1.pop_front() : 2'b01;
    check("w1_result", {co1, s1}, exp1);
    step();
    check("w1_in_ready_back", ir1, 1);

    for (int i = 0; i < 500; i++) begin
      run_op(8'($urandom), 8'($urandom), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
